mem_responder: RTL and testbench

- Multicycle data-memory responder: the far end of the MemRead/MemWrite request that the control/execute path issues.
- Accepts one word read or write per transaction from the memory stage.
- Holds the requester with Stall for a fixed latency, then returns Done (and read data).
- Contains its own word-addressed storage array; replaces the single-cycle data memory in the memory stage.

---
 rtl/mem_responder_pkg.sv | 13 +
 rtl/mem_responder_mem_array.sv | 26 ++
 rtl/mem_responder.sv | 120 ++++++++++++
 tb/tb_mem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the multicycle data-memory responder:
// FSM state encoding and the memory word width.
package mem_responder_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word storage with a registered read port.
// The array has no reset; its contents are undefined until written.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = WORD_W
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] widx,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // The read is read-first; the responder never reads and writes in the same cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
        rdata <= mem[widx];
    end

endmodule

// File: rtl/mem_responder.sv
// Multicycle data-memory responder: accepts one word read or write, stalls
// the requester for LATENCY cycles, then pulses Done with the read data.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] Addr,
    input  logic [WORD_W-1:0] DataIn,
    input  logic              Rd,
    input  logic              Wr,
    output logic [WORD_W-1:0] DataOut,
    output logic              Stall,
    output logic              Done,
    output logic              err
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic [DEPTH_LOG2-1:0] widx_q;
    logic [WORD_W-1:0]     wdata_q;
    logic                  op_wr_q;
    logic                  req_any;
    logic                  req_legal;
    logic                  illegal;
    logic                  accept;
    logic                  fire;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic [WORD_W-1:0]     mem_rdata;
    logic                  unused_addr;

    // High address bits only select the wrap-around alias and are ignored.
    assign unused_addr = ^Addr;

    assign req_any   = Rd | Wr;
    assign req_legal = (Rd ^ Wr) && !Addr[0];
    assign illegal   = (state == IDLE) && req_any && !req_legal;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (req_any && req_legal) begin
                    accept    = 1'b1;
                    cnt_nxt   = LAT_M1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    fire      = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            DataOut <= '0;
            Stall   <= 1'b0;
            Done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Stall <= (state_nxt == BUSY);
            Done  <= (state_nxt == RESP);
            err   <= illegal;
            if (fire && !op_wr_q) begin
                DataOut <= mem_rdata;
            end
        end
    end

    // Latched request copy; only consulted after an accept, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            widx_q  <= Addr[DEPTH_LOG2:1];
            wdata_q <= DataIn;
            op_wr_q <= Wr;
        end
    end

    // In IDLE the array is pre-read at the incoming address so that even a
    // one-cycle BUSY has valid read data at the commit edge.
    assign mem_idx = (state == IDLE) ? Addr[DEPTH_LOG2:1] : widx_q;

    mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (WORD_W)
    ) u_mem_array (
        .clk  (clk),
        .we   (fire && op_wr_q),
        .widx (mem_idx),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a driver pushes expected responses
// computed from a word-array model, a monitor pops them as Done/err appear.
module tb_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0, din = '0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [15:0] dout;
    logic        stall, done, err;

    logic [15:0] addr1 = '0, din1 = '0;
    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [15:0] dout1;
    logic        stall1, done1, err1;

    mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
        .clk(clk), .rst_n(rst_n), .Addr(addr), .DataIn(din), .Rd(rd), .Wr(wr),
        .DataOut(dout), .Stall(stall), .Done(done), .err(err)
    );

    mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .Addr(addr1), .DataIn(din1), .Rd(rd1), .Wr(wr1),
        .DataOut(dout1), .Stall(stall1), .Done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        bit          chk_data;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] model [256];
    bit          known [256];
    int          checks = 0;
    int          errors = 0;
    bit          in_resp = 0;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && (done || err)) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response done=%0b err=%0b expected none (cycle %0d)", done, err, cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("resp_kind_err", err, e.is_err);
                chk("resp_kind_done", done, !e.is_err);
                chk("resp_cycle", cyc, e.cyc);
                if (done && e.chk_data) chk("read_data", dout, e.data);
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
        if (k > 0) in_resp = 0;
    endtask

    // Called at a negedge. A request issued during RESP is only taken one edge later.
    task automatic do_txn(input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input bit perturb);
        int   n;
        int   stalls;
        bit   legal;
        bit   got;
        exp_t e;
        int   idx;
        legal = (r ^ w) && !a[0];
        idx   = int'(a[8:1]);
        n     = in_resp ? cyc + 2 : cyc + 1;
        rd = r; wr = w; addr = a; din = d;
        e.is_err   = !legal;
        e.cyc      = legal ? n + LAT : n;
        e.chk_data = 0;
        e.data     = '0;
        if (legal && r) begin
            e.chk_data = known[idx];
            e.data     = model[idx];
        end
        if (legal && w) begin
            model[idx] = d;
            known[idx] = 1;
        end
        expq.push_back(e);
        while (cyc < n) @(negedge clk);
        if (!legal) begin
            chk("stall_on_err", stall, 0);
            chk("done_on_err", done, 0);
            rd = 0; wr = 0;
            in_resp = 0;
        end else begin
            stalls = 0;
            got    = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                if (done) begin
                    got = 1;
                end else begin
                    if (stall) stalls++;
                    if (perturb && k == 1) begin
                        addr = 16'h0030; din = ~d; rd = w; wr = r;
                    end
                    @(negedge clk);
                end
            end
            chk("done_seen", got, 1);
            chk("stall_cycles", stalls, LAT);
            chk("stall_at_done", stall, 0);
            rd = 0; wr = 0;
            in_resp = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, w0, d_first, d_second, nd;
        bit got;
        repeat (3) @(negedge clk);
        chk("reset_dataout", dout, 0);
        chk("reset_stall", stall, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        rst_n = 1;
        idle(2);

        do_txn(0, 1, 16'h0010, 16'hBEEF, 0);
        do_txn(1, 0, 16'h0010, 16'h0000, 0);
        idle(1);
        do_txn(1, 1, 16'h0020, 16'h0000, 0);
        do_txn(0, 1, 16'h0012, 16'h7777, 0);
        idle(2);
        do_txn(1, 0, 16'h0013, 16'h0000, 0);
        do_txn(1, 0, 16'h0012, 16'h0000, 0);
        do_txn(0, 1, 16'h0004, 16'h1234, 0);
        do_txn(1, 0, 16'h0204, 16'h0000, 0);
        do_txn(0, 1, 16'h0030, 16'h3030, 0);
        do_txn(1, 0, 16'h0010, 16'h0000, 1);
        do_txn(0, 1, 16'h0040, 16'h0040, 0);
        do_txn(0, 1, 16'h0040, 16'h0040, 0);

        for (int t = 0; t < 60; t++) begin
            int          sel;
            logic [15:0] a;
            logic [15:0] d;
            sel = $urandom_range(0, 99);
            a   = 16'($urandom) & 16'hFE1E;
            d   = 16'($urandom);
            if (sel < 45)      do_txn(1, 0, a, d, sel < 10);
            else if (sel < 85) do_txn(0, 1, a, d, sel > 80);
            else if (sel < 92) do_txn(1, 1, a, d, 0);
            else if ($urandom_range(0, 1) == 1) do_txn(1, 0, a | 16'h0001, d, 0);
            else               do_txn(0, 1, a | 16'h0001, d, 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        do_txn(0, 1, 16'h0040, 16'hAAAA, 0);
        idle(1);
        wr = 1; addr = 16'h0040; din = 16'h5555;
        @(negedge clk);
        chk("midop_busy1_stall", stall, 1);
        @(negedge clk);
        chk("midop_busy2_stall", stall, 1);
        #2 rst_n = 0;
        #1;
        chk("midop_rst_stall", stall, 0);
        chk("midop_rst_done", done, 0);
        chk("midop_rst_err", err, 0);
        chk("midop_rst_dataout", dout, 0);
        wr = 0;
        @(negedge clk);
        rst_n = 1;
        idle(1);
        do_txn(1, 0, 16'h0040, 16'h0000, 0);
        idle(10);
        chk("queue_drained", expq.size(), 0);

        wr1 = 1; addr1 = 16'h0008; din1 = 16'h00AB;
        w0 = cyc;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (done1) got = 1;
        end
        chk("l1_write_done", got, 1);
        chk("l1_write_cycle", cyc, w0 + 2);
        c0 = cyc;
        wr1 = 0; rd1 = 1;
        d_first = 0; d_second = 0; nd = 0;
        for (int k = 0; k < 20 && nd < 2; k++) begin
            @(negedge clk);
            if (done1) begin
                chk("l1_read_data", dout1, 16'h00AB);
                if (nd == 0) d_first = cyc; else d_second = cyc;
                nd++;
            end
        end
        rd1 = 0;
        chk("l1_read_count", nd, 2);
        chk("l1_first_read_cycle", d_first, c0 + 3);
        chk("l1_done_spacing", d_second - d_first, 3);
        chk("l1_err_quiet", err1, 0);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
